// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM with bounded memory-wait timeout.
// Optional BNE decode is enabled by defining MULTICYCLE_CTRL_BNE_EN.
module multicycle_ctrl #(
  parameter int OPW   = 6,
  parameter int TMO_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           pcwrite,
  output logic           irwrite,
  output logic           regwrite,
  output logic           memwrite,
  output logic           iord,
  output logic           alusrca,
  output logic           regdst,
  output logic           memtoreg,
  output logic           branch,
  output logic           branch_ne,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic [1:0]     aluop,
  output logic           illegal,
  output logic           bus_err,
  output logic [3:0]     state_o
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    ALUWB   = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    ERR     = 4'd12
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
`endif
  localparam logic [TMO_W-1:0] CNT_TERM = {TMO_W{1'b1}};

  state_t           state_q, state_d;
  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_inc;
  logic             tmo_hit;
  logic             waiting;
  logic             illegal_q;
  logic             bne_q;

  // The wait that would push the counter to all-ones is the last one tolerated.
  assign cnt_inc = cnt_q + TMO_W'(1);
  assign tmo_hit = (cnt_inc == CNT_TERM);
  assign waiting = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= (state_d == state_q) ? cnt_inc : '0;
      illegal_q <= (state_q == DECODE) && (state_d == ERR);
    end
  end

`ifdef MULTICYCLE_CTRL_BNE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   bne_q <= 1'b0;
    else if (state_q == DECODE)  bne_q <= (opcode == OP_BNE);
  end
`else
  assign bne_q = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (mem_ready)    state_d = DECODE;
        else if (tmo_hit) state_d = ERR;
      end
      DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = RTYPEEX;
          OP_LW, OP_SW:  state_d = MEMADR;
          OP_BEQ:        state_d = BEQEX;
`ifdef MULTICYCLE_CTRL_BNE_EN
          OP_BNE:        state_d = BEQEX;
`endif
          OP_ADDI:       state_d = ADDIEX;
          OP_J:          state_d = JEX;
          default:       state_d = ERR;
        endcase
      end
      MEMADR: begin
        if (opcode == OP_LW)      state_d = MEMRD;
        else if (opcode == OP_SW) state_d = MEMWR;
        else                      state_d = FETCH;
      end
      MEMRD: begin
        if (mem_ready)    state_d = MEMWB;
        else if (tmo_hit) state_d = ERR;
      end
      MEMWR: begin
        if (mem_ready)    state_d = FETCH;
        else if (tmo_hit) state_d = ERR;
      end
      RTYPEEX: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      MEMWB, ALUWB, BEQEX, ADDIWB, JEX, ERR: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    pcwrite   = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    memwrite  = 1'b0;
    iord      = 1'b0;
    alusrca   = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    aluop     = 2'b00;
    unique case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready & ~reset;
        pcwrite = mem_ready & ~reset;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca   = 1'b1;
        aluop     = 2'b01;
        pcsrc     = 2'b01;
        branch    = ~bne_q;
        branch_ne = bne_q;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:  regwrite = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign bus_err = waiting & ~mem_ready & tmo_hit & ~reset;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, scoreboard-driven bench for multicycle_ctrl; each cycle's expected
// state and strobes are queued when stimulus is applied and checked at negedge.
module tb_multicycle_ctrl;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1, S_MEMADR = 4'd2,
                         S_MEMRD = 4'd3,  S_MEMWB  = 4'd4, S_MEMWR  = 4'd5,
                         S_RTYPE = 4'd6,  S_ALUWB  = 4'd7, S_BEQEX  = 4'd8,
                         S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JEX   = 4'd11,
                         S_ERR   = 4'd12;

  typedef struct packed {
    logic       pcwrite, irwrite, regwrite, memwrite, iord, alusrca, regdst,
                memtoreg, branch, branch_ne;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       illegal, bus_err;
  } outs_t;

  typedef struct packed {
    logic [3:0] st;
    outs_t      o;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite, irwrite, regwrite, memwrite, iord, alusrca, regdst,
              memtoreg, branch, branch_ne, illegal, bus_err;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state_o;

  int   errors = 0;
  int   checks = 0;
  int   step   = 0;
  exp_t sb[$];

  multicycle_ctrl #(.OPW(6), .TMO_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .irwrite(irwrite), .regwrite(regwrite),
    .memwrite(memwrite), .iord(iord), .alusrca(alusrca), .regdst(regdst),
    .memtoreg(memtoreg), .branch(branch), .branch_ne(branch_ne),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal),
    .bus_err(bus_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Strobe table for each state, written straight from the state descriptions.
  function automatic outs_t model(input logic [3:0] st, input logic mr,
                                  input logic ill, input logic be, input logic bne);
    outs_t o = '0;
    case (st)
      S_FETCH:  begin o.alusrcb = 2'b01; o.irwrite = mr & ~reset; o.pcwrite = mr & ~reset; end
      S_DECODE: o.alusrcb = 2'b11;
      S_MEMADR: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      S_MEMRD:  o.iord = 1'b1;
      S_MEMWB:  begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
      S_MEMWR:  begin o.iord = 1'b1; o.memwrite = 1'b1; end
      S_RTYPE:  begin o.alusrca = 1'b1; o.aluop = 2'b10; end
      S_ALUWB:  begin o.regdst = 1'b1; o.regwrite = 1'b1; end
      S_BEQEX:  begin o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01;
                      o.branch = ~bne; o.branch_ne = bne; end
      S_ADDIEX: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      S_ADDIWB: o.regwrite = 1'b1;
      S_JEX:    begin o.pcsrc = 2'b10; o.pcwrite = 1'b1; end
      default:  ;
    endcase
    o.illegal = ill;
    o.bus_err = be;
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: queue the expectation, drive, compare at negedge.
  task automatic cycle(input logic mr, input logic [3:0] st, input logic ill = 1'b0,
                       input logic be = 1'b0, input logic bne = 1'b0);
    exp_t  e;
    outs_t obs;
    sb.push_back({st, model(st, mr, ill, be, bne)});
    mem_ready = mr;
    @(negedge clk);
    e   = sb.pop_front();
    obs = {pcwrite, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg,
           branch, branch_ne, alusrcb, pcsrc, aluop, illegal, bus_err};
    check($sformatf("step%0d_state", step), 32'(state_o), 32'(e.st));
    check($sformatf("step%0d_outs", step), 32'(obs), 32'(e.o));
    step++;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [5:0] op);
    opcode = op;
    cycle(1'b1, S_FETCH);
    cycle(1'b0, S_DECODE);
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    // Reset holds FETCH with irwrite/pcwrite suppressed despite mem_ready=1.
    cycle(1'b1, S_FETCH);
    cycle(1'b1, S_FETCH);
    reset = 1'b0;

    // Load word, no waits.
    opcode = 6'b100011;
    cycle(1'b1, S_FETCH);
    cycle(1'b1, S_DECODE);
    cycle(1'b1, S_MEMADR);
    cycle(1'b1, S_MEMRD);
    cycle(1'b1, S_MEMWB);

    // Store word with three wait cycles.
    fetch_decode(6'b101011);
    cycle(1'b0, S_MEMADR);
    repeat (3) cycle(1'b0, S_MEMWR);
    cycle(1'b1, S_MEMWR);

    // R-type, mem_ready ignored outside wait states.
    fetch_decode(6'b000000);
    cycle(1'b1, S_RTYPE);
    cycle(1'b0, S_ALUWB);

    fetch_decode(6'b000100);
    cycle(1'b1, S_BEQEX);

    fetch_decode(6'b001000);
    cycle(1'b0, S_ADDIEX);
    cycle(1'b1, S_ADDIWB);

    fetch_decode(6'b000010);
    cycle(1'b1, S_JEX);

    // Undefined opcode.
    fetch_decode(6'b111111);
    cycle(1'b1, S_ERR, 1'b1);

    // Optional BNE decode.
    fetch_decode(6'b000101);
`ifdef MULTICYCLE_CTRL_BNE_EN
    cycle(1'b0, S_BEQEX, 1'b0, 1'b0, 1'b1);
`else
    cycle(1'b0, S_ERR, 1'b1);
`endif

    // Fetch timeout: bus_err on the 15th wait cycle, then ERR without illegal.
    repeat (14) cycle(1'b0, S_FETCH);
    cycle(1'b0, S_FETCH, 1'b0, 1'b1);
    cycle(1'b1, S_ERR);

    // Read completing exactly at terminal count finishes normally.
    opcode = 6'b100011;
    cycle(1'b1, S_FETCH);
    cycle(1'b0, S_DECODE);
    cycle(1'b0, S_MEMADR);
    repeat (14) cycle(1'b0, S_MEMRD);
    cycle(1'b1, S_MEMRD);
    cycle(1'b0, S_MEMWB);

    // Asynchronous reset in the middle of a store.
    fetch_decode(6'b101011);
    cycle(1'b0, S_MEMADR);
    mem_ready = 1'b0;
    #1;
    check("memwr_before_reset", 32'(memwrite), 32'd1);
    reset = 1'b1;
    #1;
    check("memwrite_async_drop", 32'(memwrite), 32'd0);
    check("state_async_reset", 32'(state_o), 32'(S_FETCH));
    check("iord_async_drop", 32'(iord), 32'd0);
    cycle(1'b1, S_FETCH);
    reset = 1'b0;
    opcode = 6'b001000;
    cycle(1'b1, S_FETCH);
    cycle(1'b0, S_DECODE);
    cycle(1'b0, S_ADDIEX);
    cycle(1'b0, S_ADDIWB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
